// File: rtl/serial_prod_collector.sv
// Tail collector for the bit-serial multiplier chain: drops lead symbols, weights and
// accumulates 2-bit partial sums, presents the product on valid/ready. Option: COLLECT_OVF_EN.
module serial_prod_collector #(
  parameter int W         = 8,
  parameter int N_SYM     = 2*W,
  parameter int LEAD_SKIP = 2
) (
  input  logic             i_clk,
  input  logic             i_arst,
  input  logic             i_start,
  input  logic             i_valid,
  input  logic [1:0]       i_sum,
  output logic [2*W-1:0]   o_result,
  output logic             o_valid,
  input  logic             i_ready,
`ifdef COLLECT_OVF_EN
  output logic             o_ovf,
`endif
  output logic             o_busy
);

  // state     | meaning
  // S_IDLE    | waiting for i_start
  // S_COLLECT | discarding lead symbols, then weighting and accumulating
  // S_HOLD    | product presented, waiting for i_ready

  localparam int RES_W  = 2*W;
  localparam int CNT_W  = ($clog2(N_SYM+1) < 1) ? 1 : $clog2(N_SYM+1);
  localparam int SKIP_W = ($clog2(LEAD_SKIP+1) < 1) ? 1 : $clog2(LEAD_SKIP+1);
`ifdef COLLECT_OVF_EN
  localparam int EXT_W  = RES_W + 2;
`else
  localparam int EXT_W  = RES_W;
`endif

  typedef enum logic [1:0] {S_IDLE, S_COLLECT, S_HOLD} state_t;

  state_t              state_q, state_d;
  logic [RES_W-1:0]    acc_q, acc_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [SKIP_W-1:0]   skip_q, skip_d;
  logic [RES_W-1:0]    res_d;
  logic                valid_d;
  logic [EXT_W-1:0]    addend;
  logic [EXT_W-1:0]    sum_ext;
`ifdef COLLECT_OVF_EN
  logic                ovf_q, ovf_d;
`endif

  always_ff @(posedge i_clk or posedge i_arst) begin
    if (i_arst) begin
      state_q  <= S_IDLE;
      acc_q    <= '0;
      cnt_q    <= '0;
      skip_q   <= '0;
      o_result <= '0;
      o_valid  <= 1'b0;
`ifdef COLLECT_OVF_EN
      ovf_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      skip_q   <= skip_d;
      o_result <= res_d;
      o_valid  <= valid_d;
`ifdef COLLECT_OVF_EN
      ovf_q    <= ovf_d;
`endif
    end
  end

  // The shifted symbol is formed wide so bits pushed past RES_W remain visible to overflow.
  always_comb begin
    addend  = EXT_W'(i_sum) << cnt_q;
    sum_ext = EXT_W'(acc_q) + addend;
  end

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    skip_d  = skip_q;
    res_d   = o_result;
    valid_d = o_valid;
`ifdef COLLECT_OVF_EN
    ovf_d   = ovf_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (i_start) begin
          state_d = S_COLLECT;
          acc_d   = '0;
          cnt_d   = '0;
          skip_d  = SKIP_W'(LEAD_SKIP);
`ifdef COLLECT_OVF_EN
          ovf_d   = 1'b0;
`endif
        end
      end
      S_COLLECT: begin
        if (i_valid) begin
          if (skip_q != '0) begin
            skip_d = skip_q - SKIP_W'(1);
          end else begin
            acc_d = sum_ext[RES_W-1:0];
            cnt_d = cnt_q + CNT_W'(1);
`ifdef COLLECT_OVF_EN
            ovf_d = ovf_q | (|sum_ext[EXT_W-1:RES_W]);
`endif
            if (cnt_q == CNT_W'(N_SYM-1)) begin
              state_d = S_HOLD;
              res_d   = sum_ext[RES_W-1:0];
              valid_d = 1'b1;
            end
          end
        end
      end
      S_HOLD: begin
        if (i_ready) begin
          valid_d = 1'b0;
          if (i_start) begin
            state_d = S_COLLECT;
            acc_d   = '0;
            cnt_d   = '0;
            skip_d  = SKIP_W'(LEAD_SKIP);
`ifdef COLLECT_OVF_EN
            ovf_d   = 1'b0;
`endif
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign o_busy = (state_q == S_COLLECT);
`ifdef COLLECT_OVF_EN
  assign o_ovf  = ovf_q;
`endif

endmodule
